// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO write and read controllers.
// The Gray helpers work on a 32-bit container; callers cast to their pointer width.
package async_fifo_pkg;

    localparam int MAX_PTR_W = 32;

    function automatic int ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // High zero bits of a narrower pointer contribute nothing to the XOR prefix.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        b = g;
        for (int i = 1; i < MAX_PTR_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_sync_nff.sv
// Multi-flop synchroniser for bringing a Gray-coded bus into the local clock domain.
module sync_nff #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of the async FIFO: RAM write port, write pointers,
// read-pointer synchroniser and registered full / almost-full / level / overflow.
module async_fifo_wr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 14,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  wr_push,
    input  logic [DATA_WIDTH-1:0] wr_din,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray_async,
    input  logic                  wr_overflow_clr,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  wr_overflow
);

    localparam int PW = ptr_w(ADDR_WIDTH);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] rq;
    logic [PW-1:0] rbin;
    logic          accept;

    sync_nff #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (wr_clk),
        .rst_n (wr_rst_n),
        .d     (rd_ptr_gray_async),
        .q     (rq)
    );

    always_comb begin
        // Gating with reset keeps the RAM from seeing a write while reset is held.
        accept  = wr_push & ~full_q & wr_rst_n;
        wbin_d  = wbin_q + PW'(accept);
        wgray_d = PW'(bin2gray(MAX_PTR_W'(wbin_d)));
        rbin    = PW'(gray2bin(MAX_PTR_W'(rq)));
        // Full: next write pointer is one lap ahead of the synchronised read pointer.
        full_d  = (wgray_d == {~rq[PW-1:PW-2], rq[PW-3:0]});
        level_d = wbin_d - rbin;
        afull_d = (level_d >= PW'(AFULL_THRESH));
        ovf_d   = ovf_q;
        if (wr_overflow_clr) ovf_d = 1'b0;
        if (wr_push && full_q) ovf_d = 1'b1;
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ram_wr_en      = accept;
    assign ram_wr_addr    = wbin_q[ADDR_WIDTH-1:0];
    assign ram_wr_data    = wr_din;
    assign wr_ptr_gray    = wgray_q;
    assign wr_full        = full_q;
    assign wr_almost_full = afull_q;
    assign wr_level       = level_q;
    assign wr_overflow    = ovf_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for the async FIFO write controller (ADDR_WIDTH=4, threshold 14, 2 sync stages).
module tb_async_fifo_wr_ctrl;

    logic       wr_clk = 1'b0;
    logic       wr_rst_n = 1'b0;
    logic       wr_push = 1'b0;
    logic [7:0] wr_din = '0;
    logic [4:0] rd_ptr_gray_async = '0;
    logic       wr_overflow_clr = 1'b0;
    logic       ram_wr_en;
    logic [3:0] ram_wr_addr;
    logic [7:0] ram_wr_data;
    logic [4:0] wr_ptr_gray;
    logic       wr_full;
    logic       wr_almost_full;
    logic [4:0] wr_level;
    logic       wr_overflow;

    int checks = 0;
    int errors = 0;

    always #5 wr_clk = ~wr_clk;

    async_fifo_wr_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(14), .SYNC_STAGES(2)
    ) dut (
        .wr_clk            (wr_clk),
        .wr_rst_n          (wr_rst_n),
        .wr_push           (wr_push),
        .wr_din            (wr_din),
        .rd_ptr_gray_async (rd_ptr_gray_async),
        .wr_overflow_clr   (wr_overflow_clr),
        .ram_wr_en         (ram_wr_en),
        .ram_wr_addr       (ram_wr_addr),
        .ram_wr_data       (ram_wr_data),
        .wr_ptr_gray       (wr_ptr_gray),
        .wr_full           (wr_full),
        .wr_almost_full    (wr_almost_full),
        .wr_level          (wr_level),
        .wr_overflow       (wr_overflow)
    );

    function automatic logic [4:0] gray5(input int n);
        logic [4:0] b;
        b = 5'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        wr_rst_n = 1'b0;
        wr_push = 1'b0;
        wr_overflow_clr = 1'b0;
        rd_ptr_gray_async = '0;
        tick();
        wr_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        wr_rst_n = 1'b0;
        wr_push = 1'b1;
        #3;
        checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0h exp 0", ram_wr_en); end
        tick();
        checks++; if (wr_ptr_gray !== 5'd0) begin errors++; $display("FAIL reset_gray got %0h exp 0", wr_ptr_gray); end
        checks++; if (wr_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", wr_level); end
        checks++; if ({wr_full, wr_almost_full, wr_overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {wr_full, wr_almost_full, wr_overflow}); end
        wr_push = 1'b0;
        wr_rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            wr_push = 1'b1;
            wr_din = 8'(i);
            #1;
            checks++; if ({ram_wr_en, ram_wr_addr, ram_wr_data} !== {1'b1, 4'(i), 8'(i)})
                begin errors++; $display("FAIL fill_port[%0d] got en=%0h addr=%0h data=%0h exp en=1 addr=%0h data=%0h", i, ram_wr_en, ram_wr_addr, ram_wr_data, i, i); end
            tick();
            if (i == 12) begin
                checks++; if (wr_almost_full !== 1'b0) begin errors++; $display("FAIL afull_after13 got %0h exp 0", wr_almost_full); end
            end
            if (i == 13) begin
                checks++; if (wr_almost_full !== 1'b1) begin errors++; $display("FAIL afull_after14 got %0h exp 1", wr_almost_full); end
            end
            if (i == 14) begin
                checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL full_after15 got %0h exp 0", wr_full); end
            end
        end
        wr_push = 1'b0;
        checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL full_after16 got %0h exp 1", wr_full); end
        checks++; if (wr_level !== 5'd16) begin errors++; $display("FAIL level_after16 got %0d exp 16", wr_level); end
        checks++; if (wr_ptr_gray !== 5'b11000) begin errors++; $display("FAIL gray_after16 got %b exp 11000", wr_ptr_gray); end
    endtask

    task automatic test_overflow();
        wr_push = 1'b1;
        wr_din = 8'hAA;
        #1;
        checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL ovf_wr_en got %0h exp 0", ram_wr_en); end
        tick();
        checks++; if (wr_ptr_gray !== 5'b11000) begin errors++; $display("FAIL ovf_gray_hold got %b exp 11000", wr_ptr_gray); end
        checks++; if (wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0h exp 1", wr_overflow); end
        wr_overflow_clr = 1'b1;
        tick();
        checks++; if (wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %0h exp 1", wr_overflow); end
        wr_push = 1'b0;
        tick();
        checks++; if (wr_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0h exp 0", wr_overflow); end
        checks++; if (wr_level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d exp 16", wr_level); end
        wr_overflow_clr = 1'b0;
    endtask

    task automatic test_release();
        rd_ptr_gray_async = 5'b00110;
        tick();
        tick();
        checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL release_full_2edges got %0h exp 1", wr_full); end
        tick();
        checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL release_full_3edges got %0h exp 0", wr_full); end
        checks++; if (wr_level !== 5'd12) begin errors++; $display("FAIL release_level got %0d exp 12", wr_level); end
        checks++; if (wr_almost_full !== 1'b0) begin errors++; $display("FAIL release_afull got %0h exp 0", wr_almost_full); end
    endtask

    task automatic test_wrap();
        logic [4:0] prev;
        bit seen_wrap;
        int bad;
        do_reset();
        prev = 5'd0;
        seen_wrap = 1'b0;
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            wr_push = 1'b1;
            wr_din = 8'(n);
            rd_ptr_gray_async = gray5(n < 4 ? 0 : n - 4);
            tick();
            if (prev == 5'b10000 && wr_ptr_gray == 5'b00000) seen_wrap = 1'b1;
            if ($countones(prev ^ wr_ptr_gray) != 1) bad++;
            if (wr_full !== 1'b0) bad++;
            if (wr_ptr_gray !== gray5(n + 1)) bad++;
            prev = wr_ptr_gray;
        end
        wr_push = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_step_errors got %0d exp 0", bad); end
        checks++; if (seen_wrap !== 1'b1) begin errors++; $display("FAIL wrap_10000_to_0 got %0h exp 1", seen_wrap); end
        checks++; if (wr_ptr_gray !== 5'b01100) begin errors++; $display("FAIL wrap_final_gray got %b exp 01100", wr_ptr_gray); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int n = 0; n < 9; n++) begin
            wr_push = 1'b1;
            wr_din = 8'(n);
            tick();
        end
        checks++; if (wr_level !== 5'd9) begin errors++; $display("FAIL mid_level_before got %0d exp 9", wr_level); end
        wr_rst_n = 1'b0;
        #1;
        checks++; if ({wr_ptr_gray, wr_level} !== 10'd0) begin errors++; $display("FAIL mid_async_ptr_level got gray=%b level=%0d exp 0", wr_ptr_gray, wr_level); end
        checks++; if ({ram_wr_en, ram_wr_addr, wr_full, wr_almost_full, wr_overflow} !== 8'd0)
            begin errors++; $display("FAIL mid_async_flags got en=%0h addr=%0h full=%0h afull=%0h ovf=%0h exp 0", ram_wr_en, ram_wr_addr, wr_full, wr_almost_full, wr_overflow); end
        #1;
        wr_rst_n = 1'b1;
        wr_din = 8'h55;
        #1;
        checks++; if ({ram_wr_en, ram_wr_addr} !== {1'b1, 4'd0}) begin errors++; $display("FAIL mid_first_push got en=%0h addr=%0h exp en=1 addr=0", ram_wr_en, ram_wr_addr); end
        tick();
        checks++; if ({wr_ptr_gray, wr_level} !== {5'b00001, 5'd1}) begin errors++; $display("FAIL mid_after_push got gray=%b level=%0d exp 00001 1", wr_ptr_gray, wr_level); end
        wr_push = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset();
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            wr_push = 1'b1;
            wr_din = 8'(n);
            rd_ptr_gray_async = gray5(n);
            tick();
            if (wr_full !== 1'b0 || wr_overflow !== 1'b0) bad++;
            if (n + 1 >= 3 && wr_level !== 5'd3) bad++;
        end
        wr_push = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_errors got %0d exp 0", bad); end
        checks++; if (wr_level !== 5'd3) begin errors++; $display("FAIL b2b_level got %0d exp 3", wr_level); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
